// File: rtl/seg_ctrl_pkg.sv
// Shared types and constants for the 7-segment serial-shift controller.
package seg_ctrl_pkg;

    localparam int SEG_W = 64;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH
    } seg_state_t;

endpackage

// File: rtl/seg_tick_gen.sv
// Half-period tick for the shift/latch timing: fires every CLK_DIV cycles,
// and a restart forces the phase back to zero so each phase starts aligned.
module seg_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/seg_shift_ctrl.sv
// Shifts a segment pattern MSB-first into the cascaded display registers,
// pulses the storage latch, and periodically re-sends the last pattern.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_CLEAR | chain clear held low for CLK_DIV cycles after reset
//   ST_IDLE  | ready for a pattern; refresh timer may trigger a re-send
//   ST_LOAD  | shadow word copied into the shift register
//   ST_SHIFT | DATA_W bits, seg_clk low then high for CLK_DIV each
//   ST_LATCH | seg_latch high then low for CLK_DIV each
module seg_shift_ctrl
    import seg_ctrl_pkg::*;
#(
    parameter int DATA_W  = SEG_W,
    parameter int CLK_DIV = 2,
    parameter int REFRESH = 2**20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              busy,
    output logic              done,
    output logic              seg_clk,
    output logic              seg_dout,
    output logic              seg_latch,
    output logic              seg_clrn
);

    localparam int BW = $clog2(DATA_W);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic [31:0]   REF_LAST = 32'(REFRESH - 1);
    localparam logic [31:0]   REF_MAX  = 32'(REFRESH);

    seg_state_t        r_state;
    seg_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_shadow;
    logic [DATA_W-1:0] r_shift;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_half;
    logic [31:0]       r_ref_cnt;
    logic              w_tick;
    logic              w_restart;
    logic              w_accept;
    logic              w_expire;
    logic              w_last_bit;

    assign w_accept   = data_valid && data_ready;
    assign w_expire   = (REFRESH != 0) && (r_state == ST_IDLE) && (r_ref_cnt == REF_LAST);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    assign w_restart  = (r_state == ST_LOAD) ||
                        ((r_state == ST_SHIFT) && (w_state_nxt == ST_LATCH));

    seg_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk       (clk),
        .rstn      (rstn),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_tick) w_state_nxt = ST_IDLE;
            ST_IDLE:  if (w_accept || w_expire) w_state_nxt = ST_LOAD;
            ST_LOAD:  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_tick && r_half && w_last_bit) w_state_nxt = ST_LATCH;
            ST_LATCH: if (w_tick && r_half) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_CLEAR;
            r_shadow   <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_half     <= 1'b0;
            r_ref_cnt  <= '0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            seg_clk    <= 1'b0;
            seg_dout   <= 1'b0;
            seg_latch  <= 1'b0;
            seg_clrn   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            data_ready <= (w_state_nxt == ST_IDLE);
            busy       <= (w_state_nxt inside {ST_LOAD, ST_SHIFT, ST_LATCH});
            done       <= (r_state == ST_LATCH) && (w_state_nxt == ST_IDLE);

            if ((r_state == ST_CLEAR) && w_tick) seg_clrn <= 1'b1;
            if (w_accept) r_shadow <= data_in;

            // Accept and refresh both enter LOAD, so one clear covers both.
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_LOAD)) begin
                r_ref_cnt <= '0;
            end else if (r_ref_cnt != REF_MAX) begin
                r_ref_cnt <= r_ref_cnt + 32'd1;
            end

            case (r_state)
                ST_LOAD: begin
                    r_shift   <= r_shadow;
                    r_bit_cnt <= '0;
                    r_half    <= 1'b0;
                    seg_clk   <= 1'b0;
                    seg_dout  <= r_shadow[DATA_W-1];
                end
                ST_SHIFT: begin
                    if (w_tick && !r_half) begin
                        r_half  <= 1'b1;
                        seg_clk <= 1'b1;
                    end else if (w_tick) begin
                        r_half  <= 1'b0;
                        seg_clk <= 1'b0;
                        r_shift <= r_shift << 1;
                        if (w_last_bit) begin
                            seg_dout  <= 1'b0;
                            seg_latch <= 1'b1;
                        end else begin
                            seg_dout  <= r_shift[DATA_W-2];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                ST_LATCH: begin
                    if (w_tick && !r_half) begin
                        r_half    <= 1'b1;
                        seg_latch <= 1'b0;
                    end else if (w_tick) begin
                        r_half <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_shift_ctrl.sv
// Directed bench for seg_shift_ctrl: four instances (CLK_DIV 2 / 2 with refresh / 1 / 5)
// observed through a shared monitor selected by sel.
module tb_seg_shift_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [63:0] din = '0;
    logic        vld = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  vsel;
    logic [3:0]  rdy, bsy, dn, sck, sdo, slt, scl;
    logic        m_rdy, m_bsy, m_dn, m_sck, m_sdo, m_slt, m_scl;

    int          cyc = 0;
    int          rises = 0;
    int          lat_rises = 0;
    int          run = 0;
    int          hi_len = 0;
    int          lo_len = 0;
    logic        p_sck = 1'b0;
    logic        p_slt = 1'b0;
    logic [63:0] cap = '0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign vsel  = vld ? (4'b0001 << sel) : 4'b0000;
    assign m_rdy = rdy[sel];
    assign m_bsy = bsy[sel];
    assign m_dn  = dn[sel];
    assign m_sck = sck[sel];
    assign m_sdo = sdo[sel];
    assign m_slt = slt[sel];
    assign m_scl = scl[sel];

    seg_shift_ctrl #(.DATA_W(64), .CLK_DIV(2), .REFRESH(0)) u_d2 (
        .clk(clk), .rstn(rstn), .data_in(din), .data_valid(vsel[0]),
        .data_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .seg_clk(sck[0]),
        .seg_dout(sdo[0]), .seg_latch(slt[0]), .seg_clrn(scl[0]));

    seg_shift_ctrl #(.DATA_W(64), .CLK_DIV(2), .REFRESH(300)) u_ref (
        .clk(clk), .rstn(rstn), .data_in(din), .data_valid(vsel[1]),
        .data_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .seg_clk(sck[1]),
        .seg_dout(sdo[1]), .seg_latch(slt[1]), .seg_clrn(scl[1]));

    seg_shift_ctrl #(.DATA_W(64), .CLK_DIV(1), .REFRESH(0)) u_c1 (
        .clk(clk), .rstn(rstn), .data_in(din), .data_valid(vsel[2]),
        .data_ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .seg_clk(sck[2]),
        .seg_dout(sdo[2]), .seg_latch(slt[2]), .seg_clrn(scl[2]));

    seg_shift_ctrl #(.DATA_W(64), .CLK_DIV(5), .REFRESH(0)) u_c5 (
        .clk(clk), .rstn(rstn), .data_in(din), .data_valid(vsel[3]),
        .data_ready(rdy[3]), .busy(bsy[3]), .done(dn[3]), .seg_clk(sck[3]),
        .seg_dout(sdo[3]), .seg_latch(slt[3]), .seg_clrn(scl[3]));

    always @(posedge clk) cyc <= cyc + 1;

    // Serial-side monitor: rises, captured data at each seg_clk rise, level run lengths.
    always @(negedge clk) begin
        if (m_sck && !p_sck) begin
            rises <= rises + 1;
            cap   <= {cap[62:0], m_sdo};
        end
        if (m_slt && !p_slt) lat_rises <= lat_rises + 1;
        if (m_sck == p_sck) begin
            run <= run + 1;
        end else begin
            if (p_sck) hi_len <= run;
            else       lo_len <= run;
            run <= 1;
        end
        p_sck <= m_sck;
        p_slt <= m_slt;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w, output int acc);
        din = w;
        vld = 1'b1;
        step(1);
        acc = cyc;
        vld = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (m_dn) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL done_timeout sel=%0d got none within %0d cycles", sel, budget);
        end
    endtask

    task automatic wait_ready(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (m_rdy) begin
                ok = 1;
                break;
            end
            step(1);
        end
        checks++;
        if (ok == 0) begin
            errors++;
            $display("FAIL ready_timeout sel=%0d", sel);
        end
    endtask

    task automatic test_reset();
        int rb;
        rstn = 1'b0;
        vld  = 1'b0;
        sel  = 2'd0;
        step(3);
        checks++;
        if ({rdy, bsy, dn, sck, sdo, slt, scl} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {rdy, bsy, dn, sck, sdo, slt, scl});
        end
        rstn = 1'b1;
        step(1);
        checks++;
        if ({m_scl, m_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL clear_edge1 got clrn,rdy=%b exp 00", {m_scl, m_rdy});
        end
        step(1);
        checks++;
        if ({m_scl, m_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL clear_edge2 got clrn,rdy=%b exp 11", {m_scl, m_rdy});
        end
        rb = rises;
        step(1000);
        checks++;
        if ((rises - rb) !== 0 || m_sck !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet got rises=%0d sclk=%b exp 0 0", rises - rb, m_sck);
        end
    endtask

    task automatic test_single_frame();
        logic [63:0] w;
        int acc, t, rb, lb;
        w   = 64'hF0F0_0000_0000_0001;
        sel = 2'd0;
        rb  = rises;
        lb  = lat_rises;
        send(w, acc);
        wait_done(400, t);
        checks++;
        if ((t - acc) !== 261) begin
            errors++;
            $display("FAIL frame_latency got %0d exp 261", t - acc);
        end
        checks++;
        if ((rises - rb) !== 64 || (lat_rises - lb) !== 1) begin
            errors++;
            $display("FAIL frame_edges got rises=%0d latches=%0d exp 64 1", rises - rb, lat_rises - lb);
        end
        checks++;
        if (cap !== w) begin
            errors++;
            $display("FAIL frame_data got %h exp %h", cap, w);
        end
        checks++;
        if ({m_rdy, m_bsy, m_sdo} !== 3'b100) begin
            errors++;
            $display("FAIL frame_end_flags got rdy,busy,dout=%b exp 100", {m_rdy, m_bsy, m_sdo});
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a;
        int acc, td, t2;
        a   = 64'hDEAD_BEEF_0123_4567;
        sel = 2'd0;
        send(a, acc);
        din = 64'h1234;
        vld = 1'b1;
        checks++;
        if ({m_rdy, m_bsy} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_busy got rdy,busy=%b exp 01", {m_rdy, m_bsy});
        end
        wait_done(400, td);
        checks++;
        if ((td - acc) !== 261 || cap !== a) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d data=%h exp 261 %h", td - acc, cap, a);
        end
        step(1);
        vld = 1'b0;
        checks++;
        if (m_bsy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_next got busy=%b exp 1", m_bsy);
        end
        wait_done(400, t2);
        checks++;
        if ((t2 - td) !== 262 || cap !== 64'h1234) begin
            errors++;
            $display("FAIL b2b_second got gap=%0d data=%h exp 262 1234", t2 - td, cap);
        end
    endtask

    task automatic test_refresh();
        logic [63:0] r, n;
        int acc, t, rb, lb, acc2;
        r   = 64'hA5A5_5A5A_C3C3_3C3C;
        n   = 64'h0123_4567_89AB_CDEF;
        sel = 2'd1;
        step(1);
        wait_ready(700);
        rb = rises;
        lb = lat_rises;
        send(r, acc);
        wait_done(400, t);
        checks++;
        if (cap !== r) begin
            errors++;
            $display("FAIL refresh_first_data got %h exp %h", cap, r);
        end
        step(acc + 299 - cyc);
        checks++;
        if (m_bsy !== 1'b0) begin
            errors++;
            $display("FAIL refresh_early got busy=%b exp 0", m_bsy);
        end
        step(1);
        checks++;
        if (m_bsy !== 1'b1) begin
            errors++;
            $display("FAIL refresh_start got busy=%b exp 1 at load+300", m_bsy);
        end
        wait_done(400, t);
        checks++;
        if (cap !== r || (rises - rb) !== 128 || (lat_rises - lb) !== 2) begin
            errors++;
            $display("FAIL refresh_resend got data=%h rises=%0d latches=%0d exp %h 128 2",
                     cap, rises - rb, lat_rises - lb, r);
        end
        step(acc + 599 - cyc);
        din = n;
        vld = 1'b1;
        step(1);
        acc2 = cyc;
        vld  = 1'b0;
        checks++;
        if (m_bsy !== 1'b1) begin
            errors++;
            $display("FAIL refresh_collide_accept got busy=%b exp 1", m_bsy);
        end
        wait_done(400, t);
        checks++;
        if ((t - acc2) !== 261 || cap !== n) begin
            errors++;
            $display("FAIL refresh_collide_data got lat=%0d data=%h exp 261 %h", t - acc2, cap, n);
        end
        step(acc2 + 299 - cyc);
        checks++;
        if (m_bsy !== 1'b0) begin
            errors++;
            $display("FAIL refresh_after_accept_early got busy=%b exp 0", m_bsy);
        end
        step(1);
        checks++;
        if (m_bsy !== 1'b1) begin
            errors++;
            $display("FAIL refresh_after_accept got busy=%b exp 1", m_bsy);
        end
        wait_done(400, t);
        checks++;
        if (cap !== n) begin
            errors++;
            $display("FAIL refresh_new_data got %h exp %h", cap, n);
        end
    endtask

    task automatic test_reset_midframe();
        int acc, rb, lb, hit;
        sel = 2'd0;
        rb  = rises;
        send(64'h8000_0000_FFFF_0001, acc);
        hit = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if ((rises - rb) == 20) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (hit == 0) begin
            errors++;
            $display("FAIL midframe_reach got rises=%0d exp 20", rises - rb);
        end
        lb = lat_rises;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({m_rdy, m_bsy, m_dn, m_sck, m_sdo, m_slt, m_scl} !== 7'b0) begin
            errors++;
            $display("FAIL midframe_async got %b exp 0000000",
                     {m_rdy, m_bsy, m_dn, m_sck, m_sdo, m_slt, m_scl});
        end
        step(3);
        rstn = 1'b1;
        step(1);
        checks++;
        if ({m_scl, m_rdy} !== 2'b00) begin
            errors++;
            $display("FAIL midframe_clear got clrn,rdy=%b exp 00", {m_scl, m_rdy});
        end
        step(1);
        checks++;
        if ({m_scl, m_rdy} !== 2'b11) begin
            errors++;
            $display("FAIL midframe_idle got clrn,rdy=%b exp 11", {m_scl, m_rdy});
        end
        rb = rises;
        step(300);
        checks++;
        if ((rises - rb) !== 0 || lat_rises !== lb) begin
            errors++;
            $display("FAIL midframe_quiet got rises=%0d latches=%0d exp 0 %0d", rises - rb, lat_rises, lb);
        end
    endtask

    task automatic test_clk_div(input logic [1:0] s, input int d, input logic [63:0] w);
        int acc, t, rb;
        sel = s;
        step(1);
        rb = rises;
        send(w, acc);
        wait_done(1000, t);
        checks++;
        if ((t - acc) !== (1 + 2 * d * 64 + 2 * d)) begin
            errors++;
            $display("FAIL div%0d_latency got %0d exp %0d", d, t - acc, 1 + 2 * d * 64 + 2 * d);
        end
        checks++;
        if (hi_len !== d || lo_len !== d) begin
            errors++;
            $display("FAIL div%0d_half got hi=%0d lo=%0d exp %0d", d, hi_len, lo_len, d);
        end
        checks++;
        if ((rises - rb) !== 64 || cap !== w) begin
            errors++;
            $display("FAIL div%0d_data got rises=%0d data=%h exp 64 %h", d, rises - rb, cap, w);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_refresh();
        test_reset_midframe();
        test_clk_div(2'd2, 1, 64'hC0FF_EE00_1357_9BDF);
        test_clk_div(2'd3, 5, 64'h7E57_0F0F_AAAA_5555);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
